// File: rtl/layer2_output_controller_pkg.sv
// ============================================================================
// Module      : layer2_output_controller_pkg
// Description : Shared constants, default sizes and FSM encoding for the
//               second dense layer stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package layer2_output_controller_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int LAYER_2_RELU_NODES    = 4;
    localparam int LAYER_2_OUTPUT_NODES  = 10;
    localparam int LAYER_2_IN_BIT_WIDTH  = 4;
    localparam int LAYER_2_WEIGHT_WIDTH  = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_MAC     = 3'd2,
        ST_BIAS    = 3'd3,
        ST_ARGMAX  = 3'd4,
        ST_DONE    = 3'd5
    } l2State_t;

endpackage

`default_nettype wire

// File: rtl/layer2_mac_lane.sv
// ============================================================================
// Module      : layer2_mac_lane
// Description : One signed accumulator for a single output node.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer2_mac_lane
    import layer2_output_controller_pkg::*;
#(
    parameter int IN_WIDTH     = LAYER_2_IN_BIT_WIDTH,
    parameter int WEIGHT_WIDTH = LAYER_2_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_clear,
    input  logic                    i_macEnable,
    input  logic                    i_biasEnable,
    input  logic [IN_WIDTH-1:0]     i_data,
    input  logic [WEIGHT_WIDTH-1:0] i_weight,
    input  logic [WEIGHT_WIDTH-1:0] i_bias,
    output logic [ACC_WIDTH-1:0]    o_acc
);

    logic [ACC_WIDTH-1:0] w_dataExt;
    logic [ACC_WIDTH-1:0] w_weightExt;
    logic [ACC_WIDTH-1:0] w_biasExt;
    logic [ACC_WIDTH-1:0] w_product;
    logic [ACC_WIDTH-1:0] r_acc;

    // Extending both operands to the full accumulator width keeps the
    // truncated product exact in two's complement.
    assign w_dataExt   = {{(ACC_WIDTH-IN_WIDTH){1'b0}}, i_data};
    assign w_weightExt = {{(ACC_WIDTH-WEIGHT_WIDTH){i_weight[WEIGHT_WIDTH-1]}}, i_weight};
    assign w_biasExt   = {{(ACC_WIDTH-WEIGHT_WIDTH){i_bias[WEIGHT_WIDTH-1]}}, i_bias};
    assign w_product   = w_dataExt * w_weightExt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_macEnable) begin
            r_acc <= r_acc + w_product;
        end else if (i_biasEnable) begin
            r_acc <= r_acc + w_biasExt;
        end
    end

    assign o_acc = r_acc;

endmodule

`default_nettype wire

// File: rtl/layer2_output_controller.sv
// ============================================================================
// Module      : layer2_output_controller
// Description : Output dense layer: capture, sequential MAC, bias, argmax.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer2_output_controller
    import layer2_output_controller_pkg::*;
#(
    parameter int RELU_NODES   = LAYER_2_RELU_NODES,
    parameter int OUTPUT_NODES = LAYER_2_OUTPUT_NODES,
    parameter int IN_WIDTH     = LAYER_2_IN_BIT_WIDTH,
    parameter int WEIGHT_WIDTH = LAYER_2_WEIGHT_WIDTH,
    localparam int ACC_WIDTH   = IN_WIDTH + WEIGHT_WIDTH + $clog2(RELU_NODES + 1) + 1,
    localparam int CLASS_WIDTH = $clog2(OUTPUT_NODES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             inputsReady,
    input  logic [RELU_NODES*IN_WIDTH-1:0]   layer1Output,
    output logic                             outputsRecieved,
    input  logic                             weightWriteEnable,
    input  logic                             biasWriteEnable,
    input  logic [9:0]                       WriteAddressSelect,
    input  logic [OUTPUT_NODES*WEIGHT_WIDTH-1:0] writeIn,
    input  logic                             classificationRecieved,
    output logic                             classificationReady,
    output logic [CLASS_WIDTH-1:0]           classification,
    output logic [OUTPUT_NODES*ACC_WIDTH-1:0] scores,
    output logic                             busy
);

    localparam int IDX_WIDTH = (RELU_NODES > 1) ? $clog2(RELU_NODES) : 1;

    l2State_t r_state;
    l2State_t w_nextState;

    logic                                w_capture;
    logic                                w_writeAllowed;
    logic                                w_lastIdx;
    logic                                w_lastNode;
    logic                                w_take;
    logic [RELU_NODES*IN_WIDTH-1:0]      r_inputs;
    logic [IN_WIDTH-1:0]                 w_inputsArr [RELU_NODES];
    logic [OUTPUT_NODES*WEIGHT_WIDTH-1:0] r_weights [RELU_NODES];
    logic [OUTPUT_NODES*WEIGHT_WIDTH-1:0] r_biases;
    logic [OUTPUT_NODES*WEIGHT_WIDTH-1:0] w_rowSel;
    logic [IDX_WIDTH-1:0]                r_idx;
    logic [CLASS_WIDTH-1:0]              r_argIdx;
    logic [CLASS_WIDTH-1:0]              r_bestIdx;
    logic [CLASS_WIDTH-1:0]              w_winIdx;
    logic [CLASS_WIDTH-1:0]              r_classification;
    logic [ACC_WIDTH-1:0]                r_bestScore;
    logic [ACC_WIDTH-1:0]                w_winScore;
    logic [ACC_WIDTH-1:0]                w_curAcc;
    logic [ACC_WIDTH-1:0]                w_accs [OUTPUT_NODES];
    logic [OUTPUT_NODES*ACC_WIDTH-1:0]   w_accFlat;
    logic [OUTPUT_NODES*ACC_WIDTH-1:0]   r_scores;

    assign w_capture      = (r_state == ST_IDLE) && inputsReady;
    assign w_writeAllowed = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_lastIdx      = (r_idx == IDX_WIDTH'(RELU_NODES - 1));
    assign w_lastNode     = (r_argIdx == CLASS_WIDTH'(OUTPUT_NODES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState         = r_state;
        outputsRecieved     = FALSE;
        busy                = FALSE;
        classificationReady = FALSE;
        case (r_state)
            ST_IDLE: begin
                if (inputsReady) w_nextState = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                outputsRecieved = TRUE;
                busy            = TRUE;
                w_nextState     = ST_MAC;
            end
            ST_MAC: begin
                busy = TRUE;
                if (w_lastIdx) w_nextState = ST_BIAS;
            end
            ST_BIAS: begin
                busy        = TRUE;
                w_nextState = ST_ARGMAX;
            end
            ST_ARGMAX: begin
                busy = TRUE;
                if (w_lastNode) w_nextState = ST_DONE;
            end
            ST_DONE: begin
                classificationReady = TRUE;
                if (classificationRecieved) w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // ---------------- Weight / bias store ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RELU_NODES; i++) r_weights[i] <= '0;
            r_biases <= '0;
        end else if (w_writeAllowed) begin
            if (weightWriteEnable && (WriteAddressSelect < 10'(RELU_NODES))) begin
                r_weights[WriteAddressSelect[IDX_WIDTH-1:0]] <= writeIn;
            end
            if (biasWriteEnable) begin
                r_biases <= writeIn;
            end
        end
    end

    // ---------------- MAC lanes ----------------
    generate
        for (genvar i = 0; i < RELU_NODES; i++) begin : g_unpackInputs
            assign w_inputsArr[i] = r_inputs[i*IN_WIDTH +: IN_WIDTH];
        end
    endgenerate

    assign w_rowSel = r_weights[r_idx];

    generate
        for (genvar k = 0; k < OUTPUT_NODES; k++) begin : g_lanes
            layer2_mac_lane #(
                .IN_WIDTH     (IN_WIDTH),
                .WEIGHT_WIDTH (WEIGHT_WIDTH),
                .ACC_WIDTH    (ACC_WIDTH)
            ) u_lane (
                .clk          (clk),
                .rst          (reset),
                .i_clear      (w_capture),
                .i_macEnable  (r_state == ST_MAC),
                .i_biasEnable (r_state == ST_BIAS),
                .i_data       (w_inputsArr[r_idx]),
                .i_weight     (w_rowSel[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                .i_bias       (r_biases[k*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
                .o_acc        (w_accs[k])
            );
            assign w_accFlat[k*ACC_WIDTH +: ACC_WIDTH] = w_accs[k];
        end
    endgenerate

    // ---------------- Argmax ----------------
    // Node 0 always seeds the running best; strict compare keeps the lowest index on ties.
    assign w_curAcc   = w_accs[r_argIdx];
    assign w_take     = (r_argIdx == '0) || ($signed(w_curAcc) > $signed(r_bestScore));
    assign w_winIdx   = w_take ? r_argIdx : r_bestIdx;
    assign w_winScore = w_take ? w_curAcc : r_bestScore;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_inputs         <= '0;
            r_idx            <= '0;
            r_argIdx         <= '0;
            r_bestIdx        <= '0;
            r_bestScore      <= '0;
            r_scores         <= '0;
            r_classification <= '0;
        end else begin
            if (w_capture) begin
                r_inputs <= layer1Output;
                r_idx    <= '0;
            end
            if (r_state == ST_MAC) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == ST_BIAS) begin
                r_argIdx <= '0;
            end
            if (r_state == ST_ARGMAX) begin
                r_argIdx    <= r_argIdx + 1'b1;
                r_bestIdx   <= w_winIdx;
                r_bestScore <= w_winScore;
                if (w_lastNode) begin
                    r_scores         <= w_accFlat;
                    r_classification <= w_winIdx;
                end
            end
        end
    end

    assign scores         = r_scores;
    assign classification = r_classification;

endmodule

`default_nettype wire

// File: tb/tb_layer2_output_controller.sv
// ============================================================================
// Module      : tb_layer2_output_controller
// Description : Directed scoreboard bench for layer2_output_controller
//               (RELU_NODES=4, OUTPUT_NODES=4, 4-bit inputs and weights).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_layer2_output_controller;

    localparam int RN  = 4;
    localparam int ON  = 4;
    localparam int AW  = 12;
    localparam int CW  = 2;

    typedef struct {
        logic [ON*AW-1:0] scores;
        logic [CW-1:0]    cls;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             inputsReady;
    logic [RN*4-1:0]  layer1Output;
    logic             outputsRecieved;
    logic             weightWriteEnable;
    logic             biasWriteEnable;
    logic [9:0]       WriteAddressSelect;
    logic [ON*4-1:0]  writeIn;
    logic             classificationRecieved;
    logic             classificationReady;
    logic [CW-1:0]    classification;
    logic [ON*AW-1:0] scores;
    logic             busy;

    int   checks   = 0;
    int   failures = 0;
    int   m_w [RN][ON];
    int   m_b [ON];
    exp_t sb [$];
    bit   ok;

    layer2_output_controller #(
        .RELU_NODES   (RN),
        .OUTPUT_NODES (ON),
        .IN_WIDTH     (4),
        .WEIGHT_WIDTH (4)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .inputsReady            (inputsReady),
        .layer1Output           (layer1Output),
        .outputsRecieved        (outputsRecieved),
        .weightWriteEnable      (weightWriteEnable),
        .biasWriteEnable        (biasWriteEnable),
        .WriteAddressSelect     (WriteAddressSelect),
        .writeIn                (writeIn),
        .classificationRecieved (classificationRecieved),
        .classificationReady    (classificationReady),
        .classification         (classification),
        .scores                 (scores),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pack4(input int a, input int b, input int c, input int d);
        return {d[3:0], c[3:0], b[3:0], a[3:0]};
    endfunction

    function automatic exp_t model(input logic [15:0] inBits);
        exp_t e;
        int   s [ON];
        int   best;
        int   bi;
        for (int k = 0; k < ON; k++) begin
            s[k] = m_b[k];
            for (int i = 0; i < RN; i++) s[k] += int'(inBits[i*4 +: 4]) * m_w[i][k];
            e.scores[k*AW +: AW] = s[k][AW-1:0];
        end
        best = s[0];
        bi   = 0;
        for (int k = 1; k < ON; k++) begin
            if (s[k] > best) begin
                best = s[k];
                bi   = k;
            end
        end
        e.cls = bi[CW-1:0];
        return e;
    endfunction

    task automatic writeRow(input int row, input logic [15:0] bits);
        weightWriteEnable  = 1'b1;
        WriteAddressSelect = 10'(row);
        writeIn            = bits;
        @(negedge clk);
        weightWriteEnable  = 1'b0;
        if (row < RN) for (int k = 0; k < ON; k++) m_w[row][k] = int'($signed(bits[k*4 +: 4]));
    endtask

    task automatic writeBias(input logic [15:0] bits);
        biasWriteEnable = 1'b1;
        writeIn         = bits;
        @(negedge clk);
        biasWriteEnable = 1'b0;
        for (int k = 0; k < ON; k++) m_b[k] = int'($signed(bits[k*4 +: 4]));
    endtask

    task automatic startInference(input logic [15:0] data, input bit doPush, output bit seen);
        if (doPush) sb.push_back(model(data));
        layer1Output = data;
        inputsReady  = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (outputsRecieved) seen = 1'b1;
        end
        inputsReady = 1'b0;
        check("capture_ack", 64'(seen), 64'd1);
    endtask

    task automatic finishInference(input bit checkLat, input bit busyWrite, input string tag);
        int   n = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (n < 60 && !seen) begin
            if (busyWrite && n == 1) begin
                check({tag, "_busy"}, 64'(busy), 64'd1);
                weightWriteEnable  = 1'b1;
                WriteAddressSelect = 10'd0;
                writeIn            = 16'h0000;
            end else begin
                weightWriteEnable = 1'b0;
            end
            @(negedge clk);
            n++;
            if (classificationReady) seen = 1'b1;
        end
        weightWriteEnable = 1'b0;
        check({tag, "_ready_seen"}, 64'(seen), 64'd1);
        if (seen) begin
            if (checkLat) check({tag, "_latency"}, 64'(n), 64'd10);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_scores"}, 64'(scores), 64'(e.scores));
                check({tag, "_class"}, 64'(classification), 64'(e.cls));
            end else begin
                check({tag, "_scoreboard_empty"}, 64'd0, 64'(sb.size() + 1));
            end
        end
    endtask

    task automatic ackResult(input string tag);
        classificationRecieved = 1'b1;
        @(negedge clk);
        classificationRecieved = 1'b0;
        check({tag, "_ready_drop"}, 64'(classificationReady), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; inputsReady = 1'b0; layer1Output = '0;
        weightWriteEnable = 1'b0; biasWriteEnable = 1'b0;
        WriteAddressSelect = '0; writeIn = '0; classificationRecieved = 1'b0;
        for (int i = 0; i < RN; i++) for (int k = 0; k < ON; k++) m_w[i][k] = 0;
        for (int k = 0; k < ON; k++) m_b[k] = 0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(classificationReady), 64'd0);
        check("rst_ack", 64'(outputsRecieved), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_scores", 64'(scores), 64'd0);
        check("rst_class", 64'(classification), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: basic inference
        writeRow(0, 16'h0300);
        writeRow(3, 16'h0100);
        writeBias(16'h0050);
        startInference(pack4(1, 2, 0, 3), 1'b1, ok);
        finishInference(1'b1, 1'b0, "t1");
        check("t1_class_const", 64'(classification), 64'd2);
        check("t1_scores_const", 64'(scores), 64'({12'd0, 12'd6, 12'd5, 12'd0}));
        check("t1_busy_done", 64'(busy), 64'd0);

        // Test 3: handshake, new request held while result pending
        layer1Output = pack4(3, 0, 0, 5);
        inputsReady  = 1'b1;
        sb.push_back(model(pack4(3, 0, 0, 5)));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_no_ack", 64'(outputsRecieved), 64'd0);
            check("t3_hold_ready", 64'(classificationReady), 64'd1);
            check("t3_hold_class", 64'(classification), 64'd2);
            check("t3_hold_scores", 64'(scores), 64'({12'd0, 12'd6, 12'd5, 12'd0}));
        end
        classificationRecieved = 1'b1;
        @(negedge clk);
        classificationRecieved = 1'b0;
        check("t3_ready_low", 64'(classificationReady), 64'd0);
        check("t3_no_ack_yet", 64'(outputsRecieved), 64'd0);
        @(negedge clk);
        check("t3_capture_ack", 64'(outputsRecieved), 64'd1);
        inputsReady = 1'b0;
        finishInference(1'b1, 1'b0, "t3");
        ackResult("t3");

        // Test 2: negative weights, biases and a tie
        writeRow(0, 16'h0000);
        writeRow(3, 16'h0000);
        writeRow(1, 16'h0009);
        writeBias(16'hFFFF);
        startInference(pack4(0, 15, 0, 0), 1'b1, ok);
        finishInference(1'b0, 1'b0, "t2");
        check("t2_class_const", 64'(classification), 64'd1);
        check("t2_scores_const", 64'(scores), 64'({12'hFFF, 12'hFFF, 12'hFFF, 12'hF96}));
        ackResult("t2");

        // Test 4: write attempted while busy is ignored
        writeRow(1, 16'h0000);
        writeBias(16'h0050);
        writeRow(0, 16'h0300);
        writeRow(3, 16'h0100);
        startInference(pack4(1, 2, 0, 3), 1'b1, ok);
        finishInference(1'b1, 1'b1, "t4a");
        check("t4a_score2", 64'(scores[2*AW +: AW]), 64'd6);
        ackResult("t4a");
        startInference(pack4(1, 2, 0, 3), 1'b1, ok);
        finishInference(1'b0, 1'b0, "t4b");
        check("t4b_class_const", 64'(classification), 64'd2);
        check("t4b_score2", 64'(scores[2*AW +: AW]), 64'd6);
        ackResult("t4b");

        // Test 6: out-of-range row is ignored
        writeRow(7, 16'h7777);
        startInference(pack4(1, 2, 0, 3), 1'b1, ok);
        finishInference(1'b0, 1'b0, "t6");
        check("t6_class_const", 64'(classification), 64'd2);
        check("t6_scores_const", 64'(scores), 64'({12'd0, 12'd6, 12'd5, 12'd0}));
        ackResult("t6");

        // Test 5: reset two edges into MAC
        startInference(pack4(1, 2, 0, 3), 1'b0, ok);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_async_busy", 64'(busy), 64'd0);
        check("t5_async_scores", 64'(scores), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < RN; i++) for (int k = 0; k < ON; k++) m_w[i][k] = 0;
        for (int k = 0; k < ON; k++) m_b[k] = 0;
        check("t5_ready", 64'(classificationReady), 64'd0);
        check("t5_ack", 64'(outputsRecieved), 64'd0);
        check("t5_class", 64'(classification), 64'd0);
        repeat (12) @(negedge clk);
        check("t5_no_ready_later", 64'(classificationReady), 64'd0);
        check("t5_idle_busy", 64'(busy), 64'd0);
        startInference(pack4(1, 2, 0, 3), 1'b1, ok);
        finishInference(1'b0, 1'b0, "t5");
        check("t5_class_const", 64'(classification), 64'd0);
        check("t5_scores_const", 64'(scores), 64'd0);
        ackResult("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
